// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared quarter-unit, coin, error and FSM encodings for the vending coin path
package vend_pkg;

  typedef enum logic [3:0] {
    Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q_INVALID
  } quarter_t;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_Q25  = 2'b01,
    COIN_Q50  = 2'b10,
    COIN_Q100 = 2'b11
  } coin_sel_t;

  typedef enum logic [1:0] {
    ERRC_NONE         = 2'd0,
    ERRC_BAD_INPUT    = 2'd1,
    ERRC_INSUFFICIENT = 2'd2,
    ERRC_TIMEOUT      = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CALC, ST_REQ, ST_WAIT_LOW, ST_GAP, ST_DONE, ST_ERR
  } disp_state_t;

  function automatic logic [3:0] coin_value(input logic [1:0] sel);
    case (sel)
      COIN_Q100: coin_value = 4'd4;
      COIN_Q50:  coin_value = 4'd2;
      COIN_Q25:  coin_value = 4'd1;
      default:   coin_value = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_greedy_sel.sv
// rtl/coin_greedy_sel.sv - largest coin not exceeding the amount owed, plus its value in quarters
module coin_greedy_sel
  import vend_pkg::*;
(
  input  logic [3:0] amount,
  output logic [1:0] sel,
  output logic [3:0] value
);

  always_comb begin
    if (amount >= Q4)
      sel = COIN_Q100;
    else if (amount >= Q2)
      sel = COIN_Q50;
    else if (amount >= Q1)
      sel = COIN_Q25;
    else
      sel = COIN_NONE;
    value = coin_value(sel);
  end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays credit-price change one coin at a time over a req/ack handshake
module change_dispenser
  import vend_pkg::*;
#(
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 1000,
  parameter int CNT_W       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] credit,
  input  logic [3:0] price,
  input  logic       coin_ack,
  output logic       coin_req,
  output logic [1:0] coin_sel,
  output logic [3:0] change_left,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  disp_state_t      state, state_n;
  logic [3:0]       credit_q, credit_q_n, price_q, price_q_n;
  logic [3:0]       change_left_n;
  logic [1:0]       coin_sel_n, err_code_n;
  logic             coin_req_n, busy_n, done_n, err_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             timeout_hit, gap_hit;
  logic [3:0]       diff, greedy_in, greedy_value, left_after;
  logic [1:0]       greedy_sel;

  assign diff        = credit_q - price_q;
  assign cnt_inc     = cnt + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(ACK_TIMEOUT));
  assign gap_hit     = (cnt_inc == CNT_W'(GAP_CYCLES));
  // change_left is stable through REQ/WAIT_LOW, so its greedy value is the coin in flight
  assign greedy_in   = (state == ST_CALC) ? diff : change_left;
  assign left_after  = change_left - greedy_value;

  coin_greedy_sel u_greedy (
    .amount (greedy_in),
    .sel    (greedy_sel),
    .value  (greedy_value)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      credit_q    <= '0;
      price_q     <= '0;
      change_left <= '0;
      coin_sel    <= COIN_NONE;
      coin_req    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERRC_NONE;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      credit_q    <= credit_q_n;
      price_q     <= price_q_n;
      change_left <= change_left_n;
      coin_sel    <= coin_sel_n;
      coin_req    <= coin_req_n;
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
      err_code    <= err_code_n;
      cnt         <= cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    credit_q_n    = credit_q;
    price_q_n     = price_q;
    change_left_n = change_left;
    coin_sel_n    = coin_sel;
    coin_req_n    = coin_req;
    busy_n        = busy;
    done_n        = 1'b0;
    err_n         = 1'b0;
    err_code_n    = err_code;
    cnt_n         = cnt;

    case (state)
      ST_IDLE: begin
        if (start) begin
          credit_q_n = credit;
          price_q_n  = price;
          err_code_n = ERRC_NONE;
          busy_n     = 1'b1;
          cnt_n      = '0;
          state_n    = ST_CALC;
        end
      end

      ST_CALC: begin
        if (credit_q > Q8 || price_q > Q8) begin
          err_n      = 1'b1;
          err_code_n = ERRC_BAD_INPUT;
          state_n    = ST_ERR;
        end else if (price_q > credit_q) begin
          err_n      = 1'b1;
          err_code_n = ERRC_INSUFFICIENT;
          state_n    = ST_ERR;
        end else begin
          change_left_n = diff;
          if (diff == Q0) begin
            done_n  = 1'b1;
            state_n = ST_DONE;
          end else begin
            coin_sel_n = greedy_sel;
            coin_req_n = 1'b1;
            cnt_n      = '0;
            state_n    = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        cnt_n = cnt_inc;
        if (coin_ack) begin
          coin_req_n = 1'b0;
          cnt_n      = '0;
          state_n    = ST_WAIT_LOW;
        end else if (timeout_hit) begin
          coin_req_n = 1'b0;
          coin_sel_n = COIN_NONE;
          err_n      = 1'b1;
          err_code_n = ERRC_TIMEOUT;
          state_n    = ST_ERR;
        end
      end

      ST_WAIT_LOW: begin
        cnt_n = cnt_inc;
        if (!coin_ack) begin
          change_left_n = left_after;
          coin_sel_n    = COIN_NONE;
          cnt_n         = '0;
          if (left_after == Q0) begin
            done_n  = 1'b1;
            state_n = ST_DONE;
          end else begin
            state_n = ST_GAP;
          end
        end else if (timeout_hit) begin
          // ack stuck high: the coin never completed, so it is not deducted
          coin_sel_n = COIN_NONE;
          err_n      = 1'b1;
          err_code_n = ERRC_TIMEOUT;
          state_n    = ST_ERR;
        end
      end

      ST_GAP: begin
        cnt_n = cnt_inc;
        if (gap_hit) begin
          coin_sel_n = greedy_sel;
          coin_req_n = 1'b1;
          cnt_n      = '0;
          state_n    = ST_REQ;
        end
      end

      ST_DONE: begin
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end

      ST_ERR: begin
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule
